// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB front-end arbiter.
package apb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Returned to the granted requester when a transfer is abandoned by the timeout.
  localparam logic [DATA_W-1:0] ABORT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_select.sv
// Round-robin winner selection between two requesters; ties go to the one not granted last.
module arb_rr_select (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB_Master front-end between two bus requesters, one transfer at a time.
// Optional WAIT-state timeout with forced abort is built when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transfer outstanding; arbitrate pending/new requests
// ISSUE | transfer pulse to APB_Master for the latched request
// WAIT  | waiting for ready (or timeout) from APB_Master
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              m0_transfer,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_transfer,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              transfer,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  output logic              timeout_err
);

  arb_state_t        r_state;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_pend0;
  logic              r_pend1;
  logic              r_transfer;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req0;
  logic              w_req1;
  logic              w_valid;
  logic              w_winner;
  logic              w_abort;
  logic              w_done;
  logic [DATA_W-1:0] w_ret_data;

  // A live pulse counts in IDLE so an idle arbiter issues on the very next cycle.
  assign w_req0 = r_pend0 | m0_transfer;
  assign w_req1 = r_pend1 | m1_transfer;

  arb_rr_select u_sel (
    .i_req0      (w_req0),
    .i_req1      (w_req1),
    .i_last_grant(r_last_grant),
    .o_valid     (w_valid),
    .o_winner    (w_winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  // ready wins over a coinciding timeout.
  assign w_abort = (r_state == WAIT) && !ready && (r_cnt == CNT_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT && !ready)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_abort)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign w_done     = (r_state == WAIT) && (ready || w_abort);
  assign w_ret_data = ready ? rdata : ABORT_RDATA;

  assign m0_ready = w_done && !r_grant;
  assign m1_ready = w_done &&  r_grant;
  assign m0_rdata = m0_ready ? w_ret_data : '0;
  assign m1_rdata = m1_ready ? w_ret_data : '0;

  assign transfer = r_transfer;
  assign write    = r_write;
  assign addr     = r_addr;
  assign wdata    = r_wdata;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
      r_transfer   <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_transfer <= 1'b0;
      r_pend0    <= r_pend0 | m0_transfer;
      r_pend1    <= r_pend1 | m1_transfer;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state      <= ISSUE;
            r_transfer   <= 1'b1;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            if (w_winner) begin
              r_write <= m1_write;
              r_addr  <= m1_addr;
              r_wdata <= m1_wdata;
              r_pend1 <= 1'b0;
            end else begin
              r_write <= m0_write;
              r_addr  <= m0_addr;
              r_wdata <= m0_wdata;
              r_pend0 <= 1'b0;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (w_done)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter with a behavioural APB_Master responder.
// Timeout scenario is compiled in when ARB_TIMEOUT_EN is defined.
module tb_apb_bus_arbiter;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          n;
    logic [31:0] rdata;
  } done_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        m0_transfer = 1'b0, m1_transfer = 1'b0;
  logic        m0_write = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata, addr, wdata;
  logic        m0_ready, m1_ready, transfer, write, timeout_err;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int t_pls[2];
  int t_xfer[2];
  int t_rdy[2];
  int slv_lat  = 3;
  bit slv_mute = 1'b0;

  int    q_order[$];
  txn_t  q_exp0[$];
  txn_t  q_exp1[$];
  done_t q_done[$];

  apb_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .timeout_err(timeout_err)
  );

  always #5 PCLK = ~PCLK;

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h1000_2000) ? 32'h0000_00A5 : (a ^ 32'h3C3C_F00F);
  endfunction

  // APB_Master stand-in: ready/rdata slv_lat cycles after each transfer pulse.
  initial forever begin
    @(negedge PCLK);
    if (transfer && !PRESET && !slv_mute) begin
      logic [31:0] a;
      a = addr;
      repeat (slv_lat) @(posedge PCLK);
      #1;
      ready = 1'b1;
      rdata = slv_data(a);
      @(posedge PCLK);
      #1;
      ready = 1'b0;
      rdata = '0;
    end
  end

  // Issue monitor: the granted requester's request must reach APB_Master unmodified.
  initial forever begin
    @(negedge PCLK);
    if (transfer) begin
      if (q_order.size() == 0) begin
        chk("unexp_xfer", 32'd1, 32'd0);
      end else begin
        int    n;
        txn_t  e;
        done_t d;
        n = q_order.pop_front();
        if ((n == 0 && q_exp0.size() == 0) || (n == 1 && q_exp1.size() == 0)) begin
          chk("grant_order", 32'(n), 32'(1 - n));
        end else begin
          e = (n == 0) ? q_exp0.pop_front() : q_exp1.pop_front();
          chk("xfer_addr", addr, e.addr);
          chk("xfer_write", 32'(write), 32'(e.wr));
          chk("xfer_wdata", wdata, e.wdata);
          d.n     = n;
          d.rdata = slv_mute ? 32'hDEAD_BEEF : slv_data(e.addr);
          q_done.push_back(d);
          t_xfer[n] = cyc;
        end
      end
    end
  end

  // Completion monitor: ready/rdata steered only to the granted requester.
  initial forever begin
    @(negedge PCLK);
    if (m0_ready || m1_ready) begin
      if (q_done.size() == 0) begin
        chk("unexp_rdy", {30'd0, m1_ready, m0_ready}, 32'd0);
      end else begin
        done_t d;
        d = q_done.pop_front();
        chk("rdy_who", {30'd0, m1_ready, m0_ready}, (d.n == 1) ? 32'd2 : 32'd1);
        chk("rdata", (d.n == 1) ? m1_rdata : m0_rdata, d.rdata);
        chk("other_rdata", (d.n == 1) ? m0_rdata : m1_rdata, 32'd0);
        t_rdy[d.n] = cyc;
      end
    end else if (m0_rdata != 0 || m1_rdata != 0) begin
      chk("rdata_leak", m0_rdata | m1_rdata, 32'd0);
    end
  end

  task automatic pulse(input int n, input logic wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d;
    @(posedge PCLK);
    #1;
    if (n == 0) begin
      m0_write = wr; m0_addr = a; m0_wdata = d; m0_transfer = 1'b1;
      q_exp0.push_back(t);
    end else begin
      m1_write = wr; m1_addr = a; m1_wdata = d; m1_transfer = 1'b1;
      q_exp1.push_back(t);
    end
    t_pls[n] = cyc;
    @(posedge PCLK);
    #1;
    if (n == 0) m0_transfer = 1'b0;
    else        m1_transfer = 1'b0;
  endtask

  task automatic wait_rdy(input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge PCLK);
      seen = (n == 1) ? m1_ready : m0_ready;
    end
    if (!seen) chk($sformatf("rdy%0d_timeout", n), 32'd0, 32'd1);
    #1;
  endtask

  task automatic do_reset();
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_transfer"}, 32'(transfer), 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_ready"}, {30'd0, m1_ready, m0_ready}, 32'd0);
    chk({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2;
    chk_outputs_zero("rst");
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    // Single read from requester 0.
    q_order.push_back(0);
    pulse(0, 1'b0, 32'h1000_2000, 32'h0);
    wait_rdy(0, 20);
    chk("single_xfer_lat", 32'(t_xfer[0] - t_pls[0]), 32'd1);
    chk("single_rdy_lat", 32'(t_rdy[0] - t_xfer[0]), 32'd3);

    // Simultaneous requests just after reset, then continuous contention.
    do_reset();
    q_order.push_back(0);
    q_order.push_back(1);
    fork
      pulse(0, 1'b0, 32'h2000_0010, 32'h0);
      pulse(1, 1'b1, 32'h2000_0020, 32'h1234_5678);
    join
    wait_rdy(0, 20);
    wait_rdy(1, 20);
    chk("simul_xfer1_gap", 32'(t_xfer[1] - t_rdy[0]), 32'd2);

    for (int k = 0; k < 3; k++) begin
      q_order.push_back(0);
      q_order.push_back(1);
    end
    fork
      begin
        pulse(0, 1'b0, 32'h3000_0000, 32'h0);
        wait_rdy(0, 40);
        pulse(0, 1'b1, 32'h3000_0004, 32'hCAFE_0001);
        wait_rdy(0, 40);
        pulse(0, 1'b0, 32'h3000_0008, 32'h0);
        wait_rdy(0, 40);
      end
      begin
        pulse(1, 1'b1, 32'h1000_1000, 32'h0000_0055);
        wait_rdy(1, 40);
        pulse(1, 1'b1, 32'h1000_1004, 32'hA5A5_5A5A);
        wait_rdy(1, 40);
        pulse(1, 1'b0, 32'h1000_1008, 32'h0);
        wait_rdy(1, 40);
      end
    join
    chk("contend_drain", 32'(q_order.size()), 32'd0);

    // Requester 1 pulses while requester 0 is in WAIT.
    q_order.push_back(0);
    q_order.push_back(1);
    pulse(0, 1'b0, 32'h4000_0000, 32'h0);
    pulse(1, 1'b1, 32'h4000_0100, 32'h0BAD_F00D);
    wait_rdy(0, 20);
    wait_rdy(1, 20);
    chk("pend_xfer1_gap", 32'(t_xfer[1] - t_rdy[0]), 32'd2);

    // Reset two cycles into WAIT with requester 1 pending.
    slv_lat = 8;
    q_order.push_back(0);
    pulse(0, 1'b1, 32'h5000_0000, 32'hFFFF_0000);
    pulse(1, 1'b0, 32'h5000_0100, 32'h0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    q_done.delete();
    q_exp1.delete();
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    repeat (15) @(negedge PCLK);
    chk("midrst_no_issue", 32'(q_exp1.size()), 32'd0);
    slv_lat = 3;

`ifdef ARB_TIMEOUT_EN
    // APB_Master never answers: forced abort at WAIT cycle 8.
    slv_mute = 1'b1;
    q_order.push_back(0);
    pulse(0, 1'b0, 32'h6000_0000, 32'h0);
    wait_rdy(0, 30);
    chk("to_rdy_lat", 32'(t_rdy[0] - t_xfer[0]), 32'd8);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    slv_mute = 1'b0;
    q_order.push_back(0);
    pulse(0, 1'b0, 32'h6000_0004, 32'h0);
    wait_rdy(0, 30);
    chk("to_next_lat", 32'(t_rdy[0] - t_xfer[0]), 32'd3);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    chk("terr_tied", 32'(timeout_err), 32'd0);
`endif

    repeat (5) @(negedge PCLK);
    chk("final_order_empty", 32'(q_order.size()), 32'd0);
    chk("final_done_empty", 32'(q_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1);
  end

endmodule

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Two-requester arbiter that shares the single APB_Master front-end (transfer/ready/write/addr/wdata/rdata) between the CPU_RV32I bus port (requester 0) and a second bus master such as a DMA or debug engine (requester 1). It sits between the requesters and APB_Master in MCU. It captures request pulses, grants round-robin, issues exactly one transfer at a time and steers rdata/ready back to the granted requester.

## Interface
- TIMEOUT_CYCLES, 256, cycles spent in WAIT before a forced abort; used only with ARB_TIMEOUT_EN.
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- m0_transfer / m1_transfer  in  1  one-cycle request pulse from requester N.
- m0_write / m1_write  in  1  1 = write; held stable until mN_ready.
- m0_addr / m1_addr  in  32  byte address; held stable until mN_ready.
- m0_wdata / m1_wdata  in  32  write data; held stable until mN_ready.
- m0_rdata / m1_rdata  out  32  read data; valid when mN_ready = 1, else 0.
- m0_ready / m1_ready  out  1  one-cycle completion pulse to requester N.
- transfer  out  1  one-cycle request pulse to APB_Master.
- write  out  1  latched write flag to APB_Master.
- addr  out  32  latched address to APB_Master.
- wdata  out  32  latched write data to APB_Master.
- rdata  in  32  read data from APB_Master.
- ready  in  1  completion pulse from APB_Master.
- timeout_err  out  1  sticky abort flag; cleared only by PRESET.

## Operation
- pend0/pend1 flags: set on mN_transfer, cleared when N is granted. A transfer while pendN is already set is ignored.
- last_grant register: reset to 1, so requester 0 wins the first tie.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE, with (pendN or mN_transfer) for any N:
  - Select the winner. If exactly one requester is active, it wins. If both are active, the winner is the one ≠ last_grant.
  - Latch the winner's write/addr/wdata into output registers.
  - Set grant = winner, last_grant = winner, clear the winner's pending flag.
  - Go to ISSUE.
- ISSUE: transfer = 1 for exactly this cycle; go to WAIT.
- WAIT: when ready = 1:
  - m{grant}_ready = ready and m{grant}_rdata = rdata, combinationally in the same cycle.
  - Go to IDLE.
- A requester may pulse a new transfer in the same cycle as its own mN_ready; it is captured as pending.
- ready outside WAIT is ignored; no mN_ready is generated.
- The non-granted requester sees mN_ready = 0 and mN_rdata = 0 at all times.
- Reset values: state IDLE; transfer 0; write 0; addr 0; wdata 0; m0/m1_ready 0; m0/m1_rdata 0; pend0/pend1 0; timeout_err 0.
- Reset asserted mid-transaction aborts it with no ready pulse and discards pending requests.

## Timing
- Request pulse at cycle T with the arbiter idle: transfer = 1 at T+1.
- APB_Master ready at cycle R: mN_ready = 1 at R, with zero added return latency.
- Back-to-back: with the other requester pending, its transfer asserts at R+2 (IDLE at R+1, ISSUE at R+2).
- Arbitration overhead is 2 cycles per transaction.
- Fairness under continuous contention: strict alternation 0,1,0,1…

## Configuration
- Macro ARB_TIMEOUT_EN, defined:
  - An 8+-bit counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT and increments each WAIT cycle without ready.
  - When count reaches TIMEOUT_CYCLES-1 without ready: m{grant}_ready = 1 and m{grant}_rdata = 32'hDEAD_BEEF for one cycle, timeout_err set, FSM goes to IDLE.
  - If ready and the timeout coincide, ready takes precedence: normal completion, no error.
- Macro ARB_TIMEOUT_EN, undefined:
  - No counter; WAIT lasts until ready.
  - timeout_err tied to 0.

## Structure
- Package apb_arb_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT)
  - the DATA_W = 32 and ADDR_W = 32 constants
  - the ABORT_RDATA = 32'hDEAD_BEEF constant.
- One sub-module, arb_rr_select, is natural: combinational winner selection from (req0, req1, last_grant) producing (valid, winner).

## Test plan
- Single read: m0 reads 0x1000_2000, APB_Master returns rdata 0x0000_00A5 after 3 cycles → transfer at T+1; m0_ready with m0_rdata 0xA5; m1_ready stays 0.
- Simultaneous requests: both pulse at the same cycle just after reset → m0 granted first with addr from m0; m1's transfer 2 cycles after m0_ready.
- Contention fairness: both requesters re-request immediately, 6 transactions → grant order 0,1,0,1,0,1; each write's addr/wdata reach APB_Master unmodified (e.g. m1 write 0x1000_1000 ← 0x55).
- Pending during busy: m1 pulses while m0 is in WAIT → m1 is not lost; m1 is served right after m0_ready.
- Reset mid-WAIT: assert PRESET 2 cycles into WAIT → all outputs 0 immediately; no mN_ready; a later ready is ignored.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, ready never returns → m0_ready at WAIT cycle 8 with rdata 0xDEAD_BEEF; timeout_err = 1 and stays 1; next request is served normally.
